spi_eeprom_seq: RTL

- Wishbone master that sequences the existing Wishbone SPI master core to run complete 25xx-series EEPROM byte transactions (write-enable, write, status polling, read).
- Sits between a simple request/response client port and the SPI core's slave bus, replacing hand-issued command words.
- Pushes 11-bit command words `{cmd[2:0], byte[7:0]}` to the data register at 0x10. Programs the baud register at 0x20 once after reset.

---
 rtl/spi_eeprom_seq.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_eeprom_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_eeprom_seq
//
// Wishbone master that drives a Wishbone SPI master core to carry out complete
// 25xx-series EEPROM single-byte transactions for a simple request/response
// client. It replaces hand-issued command words.
//
// Command words {cmd[2:0], byte[7:0]} are zero-extended to 32 bits and written
// to the core data register (0x10). The core baud register (0x20) is programmed
// once after reset. Received bytes are polled from 0x10, where bit 8 flags a
// valid byte in bits 7:0.
//
// Optional build macro: SPI_EEPROM_SEQ_VERIFY_EN
//   When defined, every successful write is followed by a read-back of the
//   same address. A mismatch or a receive timeout sets rsp_err_o, and
//   rsp_rdata_o returns the byte that was read back.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake (one outstanding request)
//   req_we_i             1 = write byte, 0 = read byte
//   req_addr_i           EEPROM byte address
//   req_wdata_i          write data
//   rsp_valid_o          one-cycle completion pulse
//   rsp_rdata_o          read data (0 for writes unless verify is enabled)
//   rsp_err_o            timeout / verify-mismatch flag, valid with rsp_valid_o
//   wbm_*                Wishbone master towards the SPI core
// -----------------------------------------------------------------------------
module spi_eeprom_seq #(
    parameter logic [10:0] BAUD_WORD = 11'h019,
    parameter int unsigned POLL_GAP  = 400,
    parameter int unsigned RX_TRIES  = 64,
    parameter int unsigned WIP_TRIES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [7:0]  req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dout_o,
    input  logic [31:0] wbm_din_i,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i
);

    localparam logic [31:0] ADDR_DATA = 32'h0000_0010;
    localparam logic [31:0] ADDR_BAUD = 32'h0000_0020;

    // Terminal counts; a zero parameter degenerates to a single cycle / try.
    localparam logic [15:0] GAP_LAST = (POLL_GAP  > 0) ? 16'(POLL_GAP  - 1) : 16'd0;
    localparam logic [15:0] RX_LAST  = (RX_TRIES  > 0) ? 16'(RX_TRIES  - 1) : 16'd0;
    localparam logic [15:0] WIP_LAST = (WIP_TRIES > 0) ? 16'(WIP_TRIES - 1) : 16'd0;

    typedef enum logic [4:0] {
        CFG, IDLE,
        WREN, W_INS, W_ADR, W_DAT,
        P_INS, P_RX, P_RD, P_GAP,
        R_INS, R_ADR, R_RX, R_RD, R_GAP,
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
        VFY_INS, VFY_ADR, VFY_RX, VFY_RD, VFY_GAP,
`endif
        DONE
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] wbm_addr_q;
    logic [31:0] wbm_dout_q;
    logic        wbm_we_q;
    logic        wbm_stb_q;
    logic        wbm_cyc_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [15:0] gap_cnt_q;
    logic [15:0] rx_cnt_q;
    logic [15:0] wip_cnt_q;
    logic        poll_restart_q;   // P_GAP returns to P_INS (WIP busy) instead of P_RD

    // Bus word required by the current state.
    logic        bus_en_d;
    logic        bus_we_d;
    logic [31:0] bus_addr_d;
    logic [10:0] bus_cmd_d;

    logic unused_din;
    assign unused_din = ^wbm_din_i[31:9];

    always_comb begin
        bus_en_d   = 1'b1;
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_DATA;
        bus_cmd_d  = 11'h000;
        case (state_q)
            CFG: begin
                bus_addr_d = ADDR_BAUD;
                bus_cmd_d  = BAUD_WORD;
            end
            WREN:  bus_cmd_d = 11'h306;
            W_INS: bus_cmd_d = 11'h102;
            W_ADR, R_ADR
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
            , VFY_ADR
`endif
            : bus_cmd_d = {3'b000, addr_q};
            W_DAT: bus_cmd_d = {3'b010, wdata_q};
            P_INS: bus_cmd_d = 11'h105;
            P_RX, R_RX
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
            , VFY_RX
`endif
            : bus_cmd_d = 11'h600;
            R_INS
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
            , VFY_INS
`endif
            : bus_cmd_d = 11'h103;
            P_RD, R_RD
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
            , VFY_RD
`endif
            : bus_we_d = 1'b0;
            default: begin
                bus_en_d   = 1'b0;
                bus_we_d   = 1'b0;
                bus_addr_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= CFG;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 8'd0;
            rsp_err_q      <= 1'b0;
            wbm_addr_q     <= 32'd0;
            wbm_dout_q     <= 32'd0;
            wbm_we_q       <= 1'b0;
            wbm_stb_q      <= 1'b0;
            wbm_cyc_q      <= 1'b0;
            addr_q         <= 8'd0;
            wdata_q        <= 8'd0;
            gap_cnt_q      <= 16'd0;
            rx_cnt_q       <= 16'd0;
            wip_cnt_q      <= 16'd0;
            poll_restart_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (bus_en_d) begin
                if (!wbm_cyc_q) begin
                    // Launch. Entering a bus state always follows a cycle with
                    // cyc low, which gives the mandatory idle cycle.
                    wbm_cyc_q  <= 1'b1;
                    wbm_stb_q  <= 1'b1;
                    wbm_we_q   <= bus_we_d;
                    wbm_addr_q <= bus_addr_d;
                    wbm_dout_q <= bus_we_d ? {21'd0, bus_cmd_d} : 32'd0;
                end else if (wbm_ack_i) begin
                    wbm_cyc_q  <= 1'b0;
                    wbm_stb_q  <= 1'b0;
                    wbm_we_q   <= 1'b0;
                    wbm_addr_q <= 32'd0;
                    wbm_dout_q <= 32'd0;
                    case (state_q)
                        CFG: begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                        end
                        WREN:  state_q <= W_INS;
                        W_INS: state_q <= W_ADR;
                        W_ADR: state_q <= W_DAT;
                        W_DAT: begin
                            state_q   <= P_INS;
                            wip_cnt_q <= 16'd0;
                        end
                        P_INS: state_q <= P_RX;
                        P_RX: begin
                            state_q  <= P_RD;
                            rx_cnt_q <= 16'd0;
                        end
                        P_RD: begin
                            if (!wbm_din_i[8]) begin
                                if (rx_cnt_q == RX_LAST) begin
                                    state_q     <= DONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_rdata_q <= 8'd0;
                                end else begin
                                    rx_cnt_q       <= rx_cnt_q + 16'd1;
                                    gap_cnt_q      <= 16'd0;
                                    poll_restart_q <= 1'b0;
                                    state_q        <= P_GAP;
                                end
                            end else if (wbm_din_i[0]) begin
                                // Write still in progress.
                                if (wip_cnt_q == WIP_LAST) begin
                                    state_q     <= DONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_rdata_q <= 8'd0;
                                end else begin
                                    wip_cnt_q      <= wip_cnt_q + 16'd1;
                                    gap_cnt_q      <= 16'd0;
                                    poll_restart_q <= 1'b1;
                                    state_q        <= P_GAP;
                                end
                            end else begin
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
                                state_q <= VFY_INS;
`else
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_rdata_q <= 8'd0;
`endif
                            end
                        end
                        R_INS: state_q <= R_ADR;
                        R_ADR: state_q <= R_RX;
                        R_RX: begin
                            state_q  <= R_RD;
                            rx_cnt_q <= 16'd0;
                        end
                        R_RD: begin
                            if (wbm_din_i[8]) begin
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_rdata_q <= wbm_din_i[7:0];
                            end else if (rx_cnt_q == RX_LAST) begin
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_rdata_q <= 8'd0;
                            end else begin
                                rx_cnt_q  <= rx_cnt_q + 16'd1;
                                gap_cnt_q <= 16'd0;
                                state_q   <= R_GAP;
                            end
                        end
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
                        VFY_INS: state_q <= VFY_ADR;
                        VFY_ADR: state_q <= VFY_RX;
                        VFY_RX: begin
                            state_q  <= VFY_RD;
                            rx_cnt_q <= 16'd0;
                        end
                        VFY_RD: begin
                            if (wbm_din_i[8]) begin
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= (wbm_din_i[7:0] != wdata_q);
                                rsp_rdata_q <= wbm_din_i[7:0];
                            end else if (rx_cnt_q == RX_LAST) begin
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_rdata_q <= 8'd0;
                            end else begin
                                rx_cnt_q  <= rx_cnt_q + 16'd1;
                                gap_cnt_q <= 16'd0;
                                state_q   <= VFY_GAP;
                            end
                        end
`endif
                        default: state_q <= state_q;
                    endcase
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_valid_i && req_ready_q) begin
                            req_ready_q <= 1'b0;
                            addr_q      <= req_addr_i;
                            wdata_q     <= req_wdata_i;
                            state_q     <= req_we_i ? WREN : R_INS;
                        end
                    end
                    P_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= 16'd0;
                            state_q   <= poll_restart_q ? P_INS : P_RD;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
                    R_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= 16'd0;
                            state_q   <= R_RD;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
`ifdef SPI_EEPROM_SEQ_VERIFY_EN
                    VFY_GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= 16'd0;
                            state_q   <= VFY_RD;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
`endif
                    DONE: begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_addr_o  = wbm_addr_q;
    assign wbm_dout_o  = wbm_dout_q;
    assign wbm_we_o    = wbm_we_q;
    assign wbm_stb_o   = wbm_stb_q;
    assign wbm_cyc_o   = wbm_cyc_q;

endmodule
